// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared FSM state encodings and requester port ids
package ram_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;
endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick
//   req_i, req_d : requests from fetch and load/store ports
//   last_grant   : port granted most recently (state held by the caller)
//   valid        : at least one request present
//   grant        : winning port, the one not last granted on a tie
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic  req_i,
  input  logic  req_d,
  input  port_e last_grant,
  output logic  valid,
  output port_e grant
);
  assign valid = req_i | req_d;
  assign grant = (req_i & req_d) ? ((last_grant == PORT_I) ? PORT_D : PORT_I)
                                 : (req_d ? PORT_D : PORT_I);
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port RAM between fetch (I) and load/store (D) ports
//   clk_25mhz, rst_n        : clock and async active-low reset
//   i_req/i_addr            : fetch request, answered by i_ack + i_rdata
//   d_req/d_we/d_addr/d_wdata : load/store request, answered by d_ack + d_rdata
//   mem_*                   : RAM command, one strobe per transaction; mem_rdata 1 cycle later
//   busy, conflict_cnt      : debug status, saturating count of IDLE cycles with both reqs
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_25mhz,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);
  state_e                state_q, state_d;
  port_e                 last_q, last_d, gnt_q, gnt_d, arb_gnt;
  logic                  arb_valid;
  logic                  we_q, we_d, mem_en_q, mem_en_d, i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  take;
  rr_arb2 u_arb (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (last_q),
    .valid      (arb_valid),
    .grant      (arb_gnt)
  );
  assign take = (state_q == IDLE) && arb_valid;
  always_comb begin
    state_d  = (state_q == IDLE) ? (arb_valid ? ISSUE : IDLE) : (state_q == ISSUE) ? WAIT : IDLE;
    last_d   = take ? arb_gnt : last_q;
    gnt_d    = take ? arb_gnt : gnt_q;
    we_d     = take ? ((arb_gnt == PORT_D) & d_we) : we_q;
    addr_d   = take ? ((arb_gnt == PORT_D) ? d_addr : i_addr) : addr_q;
    wdata_d  = take ? ((arb_gnt == PORT_D) ? d_wdata : '0) : wdata_q;
    mem_en_d = take;
    i_ack_d  = (state_q == ISSUE) && (gnt_q == PORT_I);
    d_ack_d  = (state_q == ISSUE) && (gnt_q == PORT_D);
    cnt_d    = ((state_q == IDLE) && i_req && d_req && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= PORT_D;
      gnt_q    <= PORT_I;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_en_q <= 1'b0;
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mem_en_q <= mem_en_d;
      i_ack_q  <= i_ack_d;
      d_ack_q  <= d_ack_d;
      cnt_q    <= cnt_d;
    end
  end
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_en_q & we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign i_ack        = i_ack_q;
  assign d_ack        = d_ack_q;
  // RAM read data only exists in WAIT, so it is gated through rather than registered
  assign i_rdata      = (i_ack_q && !we_q) ? mem_rdata : '0;
  assign d_rdata      = (d_ack_q && !we_q) ? mem_rdata : '0;
  assign busy         = state_q != IDLE;
  assign conflict_cnt = cnt_q;
endmodule
